mem_arbiter: RTL

- Shares one multi-cycle, single-ported 16-bit memory between the fetch stage (I-port, read-only) and the memory stage (D-port, read/write).
- Serializes requests and drives the memory handshake.
- Returns a stall/done/data response to each requester.
- Sits between the fetch/memory pipeline stages and the unified backing memory, replacing the separate instruction and data memory instances.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and backing-memory handshake signals shared by
// the arbiter (slave view) and its surrounding pipeline/memory environment (master view).
interface mem_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_done;
    logic        i_stall;
    logic        i_err;

    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        d_err;

    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_err;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_wr, d_addr, d_wdata,
        input  mem_rdata, mem_done, mem_err,
        output i_rdata, i_done, i_stall, i_err,
        output d_rdata, d_done, d_stall, d_err,
        output mem_req, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_wr, d_addr, d_wdata,
        output mem_rdata, mem_done, mem_err,
        input  i_rdata, i_done, i_stall, i_err,
        input  d_rdata, d_done, d_stall, d_err,
        input  mem_req, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes fetch (read-only) and data (read/write) accesses onto one multi-cycle
// 16-bit memory, with a bounded starvation guard that eventually favours fetch.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BUSY_I = 3'd1;
    localparam logic [2:0] BUSY_D = 3'd2;
    localparam logic [2:0] ERR_I  = 3'd3;
    localparam logic [2:0] ERR_D  = 3'd4;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [2:0]  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;

    logic grant_i, grant_d;
    logic i_fin, d_fin;

    // Data wins ties until it has been granted LIMIT times in a row over a waiting fetch.
    assign grant_i = (state_q == IDLE) && bus.i_req && (!bus.d_req || (starve_q == LIMIT));
    assign grant_d = (state_q == IDLE) && bus.d_req && !grant_i;

    assign i_fin = (state_q == BUSY_I) && bus.mem_done;
    assign d_fin = (state_q == BUSY_D) && bus.mem_done;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    starve_d = 4'd0;
                    if (bus.i_addr[0]) begin
                        state_d = ERR_I;
                    end else begin
                        state_d     = BUSY_I;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = 1'b0;
                        mem_addr_d  = bus.i_addr;
                        mem_wdata_d = 16'h0000;
                    end
                end else if (grant_d) begin
                    if (!bus.i_req)
                        starve_d = 4'd0;
                    else if (starve_q < LIMIT)
                        starve_d = starve_q + 4'd1;
                    if (bus.d_addr[0]) begin
                        state_d = ERR_D;
                    end else begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = bus.d_wr;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end
                end
            end
            BUSY_I:  if (bus.mem_done) state_d = IDLE;
            BUSY_D:  if (bus.mem_done) state_d = IDLE;
            ERR_I:   state_d = IDLE;
            ERR_D:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Responses are combinational so done lands in the same cycle as mem_done.
    assign bus.i_done  = i_fin || (state_q == ERR_I);
    assign bus.i_err   = (i_fin && bus.mem_err) || (state_q == ERR_I);
    assign bus.i_rdata = i_fin ? bus.mem_rdata : 16'h0000;
    assign bus.i_stall = bus.i_req && !bus.i_done;

    assign bus.d_done  = d_fin || (state_q == ERR_D);
    assign bus.d_err   = (d_fin && bus.mem_err) || (state_q == ERR_D);
    assign bus.d_rdata = d_fin ? bus.mem_rdata : 16'h0000;
    assign bus.d_stall = bus.d_req && !bus.d_done;
endmodule
